// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: datapath width, mul/div op encodings and FSM states.
package cpu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;

  localparam logic [1:0] OP_MULLO = 2'b00;
  localparam logic [1:0] OP_MULHI = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned 32-bit multiply/divide; one shift-add or restoring-divide step
// per cycle on a shared 64-bit working register, result issued as a writeback request.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      dest,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            wb_regwrite,
  output logic [4:0]      wb_wa
);

  localparam int unsigned WW = 2 * XLEN;
  localparam int unsigned CW = $clog2(ITERS);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic [XLEN-1:0] b_q;
  logic [4:0]      dest_q;
  logic [WW-1:0]   work;
  logic [WW-1:0]   work_nxt;
  logic [XLEN:0]   acc;

  // Multiply: {product_hi, multiplier}. Divide: {remainder, dividend -> quotient}.
  always_comb begin
    work_nxt = work;
    acc      = '0;
    if (op_q == OP_MULLO || op_q == OP_MULHI) begin
      acc      = {1'b0, work[WW-1:XLEN]} + (work[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      work_nxt = {acc, work[XLEN-1:1]};
    end else begin
      acc = work[WW-1:XLEN-1];
      if (acc >= {1'b0, b_q}) begin
        work_nxt = {acc[XLEN-1:0] - b_q, work[XLEN-2:0], 1'b1};
      end else begin
        work_nxt = {work[WW-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= OP_MULLO;
      b_q         <= '0;
      dest_q      <= '0;
      work        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      wb_regwrite <= 1'b0;
      wb_wa       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            b_q    <= b;
            dest_q <= dest;
            cnt    <= '0;
            work   <= {{XLEN{1'b0}}, a};
            busy   <= 1'b1;
            // Divide by zero skips the iterations and produces the defined result directly.
            if ((op == OP_DIVU || op == OP_REMU) && b == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              wb_regwrite <= (dest != 5'd0);
              wb_wa       <= dest;
              result      <= (op == OP_REMU) ? a : {XLEN{1'b1}};
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          work <= work_nxt;
          if (cnt == CW'(ITERS - 1)) begin
            state       <= DONE;
            done        <= 1'b1;
            wb_regwrite <= (dest_q != 5'd0);
            wb_wa       <= dest_q;
            result      <= (op_q == OP_MULHI || op_q == OP_REMU) ?
                           work_nxt[WW-1:XLEN] : work_nxt[XLEN-1:0];
          end else begin
            cnt <= CW'(cnt + 1'b1);
          end
        end
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          wb_regwrite <= 1'b0;
          busy        <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          done        <= 1'b0;
          wb_regwrite <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized ops against an arithmetic model.
module tb_mul_div_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  dest;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        wb_regwrite;
  logic [4:0]  wb_wa;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dest(dest),
    .busy(busy), .done(done), .result(result), .wb_regwrite(wb_regwrite), .wb_wa(wb_wa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    case (o)
      OP_MULLO: return p[31:0];
      OP_MULHI: return p[63:32];
      OP_DIVU:  return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      default:  return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] y);
    return (o[1] && y == 32'd0) ? 1 : 33;
  endfunction

  // Issue one op and wait (bounded) for done; lat counts cycles from the accept edge to the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] d, output int lat, output logic [31:0] res,
                        output logic regw, output logic [4:0] wa, output logic busy_after);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; dest = d;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        lat = k + 1;
        break;
      end
      @(posedge clk); #1;
    end
    res  = result;
    regw = wb_regwrite;
    wa   = wb_wa;
    @(posedge clk); #1;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; dest = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0)        begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (wb_regwrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", wb_regwrite); end
    if (result !== 32'd0)     begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    if (wb_wa !== 5'd0)       begin failures++; $display("FAIL reset_wa got=%0d exp=0", wb_wa); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [8]  = '{OP_MULLO, OP_MULHI, OP_MULLO, OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_MULLO};
    logic [31:0] as  [8]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd5, 32'd5, 32'd2};
    logic [31:0] bs  [8]  = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd9, 32'd9, 32'd2};
    logic [31:0] exps[8]  = '{32'd42, 32'hFFFF_FFFE, 32'd1, 32'd14, 32'd2, 32'd0, 32'd5, 32'd4};
    logic [4:0]  ds  [8]  = '{5'd3, 5'd1, 5'd2, 5'd10, 5'd11, 5'd12, 5'd13, 5'd0};
    int lat; logic [31:0] res; logic regw; logic [4:0] wa; logic bz;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], ds[i], lat, res, regw, wa, bz);
      checks += 5;
      if (lat !== 33)           begin failures++; $display("FAIL dir%0d_latency got=%0d exp=33", i, lat); end
      if (res !== exps[i])      begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, exps[i]); end
      if (regw !== (ds[i] != 0)) begin failures++; $display("FAIL dir%0d_regwrite got=%b exp=%b", i, regw, ds[i] != 0); end
      if (wa !== ds[i])         begin failures++; $display("FAIL dir%0d_wa got=%0d exp=%0d", i, wa, ds[i]); end
      if (bz !== 1'b0)          begin failures++; $display("FAIL dir%0d_busy_after got=%b exp=0", i, bz); end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] res; logic regw; logic [4:0] wa; logic bz;
    run_op(OP_DIVU, 32'd123, 32'd0, 5'd7, lat, res, regw, wa, bz);
    checks += 4;
    if (lat !== 1)              begin failures++; $display("FAIL divz_latency got=%0d exp=1", lat); end
    if (res !== 32'hFFFF_FFFF)  begin failures++; $display("FAIL divz_result got=%h exp=ffffffff", res); end
    if (regw !== 1'b1)          begin failures++; $display("FAIL divz_regwrite got=%b exp=1", regw); end
    if (bz !== 1'b0)            begin failures++; $display("FAIL divz_busy_after got=%b exp=0", bz); end
    run_op(OP_REMU, 32'd123, 32'd0, 5'd8, lat, res, regw, wa, bz);
    checks += 3;
    if (lat !== 1)         begin failures++; $display("FAIL remz_latency got=%0d exp=1", lat); end
    if (res !== 32'd123)   begin failures++; $display("FAIL remz_result got=%h exp=7b", res); end
    if (wa !== 5'd8)       begin failures++; $display("FAIL remz_wa got=%0d exp=8", wa); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res; logic regw; logic [4:0] wa; logic bz;
    logic [1:0] o; logic [31:0] x, y; logic [4:0] d; int mode;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      mode = $urandom_range(0, 7);
      y = (mode == 0) ? 32'd0 : (mode == 1) ? 32'($urandom_range(1, 15)) :
          (mode == 2) ? 32'hFFFF_FFFF : $urandom;
      d = 5'($urandom_range(0, 31));
      run_op(o, x, y, d, lat, res, regw, wa, bz);
      checks += 4;
      if (res !== model(o, x, y)) begin failures++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, res, model(o, x, y)); end
      if (lat !== model_lat(o, y)) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, model_lat(o, y)); end
      if (regw !== (d != 0))       begin failures++; $display("FAIL rnd%0d_regwrite got=%b exp=%b", i, regw, d != 0); end
      if (wa !== d)                begin failures++; $display("FAIL rnd%0d_wa got=%0d exp=%0d", i, wa, d); end
    end
  endtask

  task automatic test_busy_ignore();
    int k; int extra;
    @(negedge clk);
    start = 1'b1; op = OP_MULLO; a = 32'd3; b = 32'd4; dest = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7; dest = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    k = -1;
    for (int j = 0; j < 100; j++) begin
      if (done) begin k = j; break; end
      @(posedge clk); #1;
    end
    checks += 3;
    if (k !== 22)          begin failures++; $display("FAIL ign_done_edge got=%0d exp=22", k); end
    if (result !== 32'd12) begin failures++; $display("FAIL ign_result got=%h exp=c", result); end
    if (wb_wa !== 5'd4)    begin failures++; $display("FAIL ign_wa got=%0d exp=4", wb_wa); end
    // start during the done cycle must be dropped
    start = 1'b1; op = OP_MULLO; a = 32'd5; b = 32'd5; dest = 5'd6;
    @(posedge clk); #1;
    start = 1'b0;
    checks += 2;
    if (busy !== 1'b0)     begin failures++; $display("FAIL donestart_busy got=%b exp=0", busy); end
    if (result !== 32'd12) begin failures++; $display("FAIL donestart_hold got=%h exp=c", result); end
    extra = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL ign_extra_done got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] res; logic regw; logic [4:0] wa; logic bz; int pulses;
    @(negedge clk);
    start = 1'b1; op = OP_MULLO; a = 32'd3; b = 32'd4; dest = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'd8; b = 32'd8; dest = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9; dest = 5'd7;
    @(posedge clk); #1;
    checks += 5;
    if (busy !== 1'b0)        begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    if (done !== 1'b0)        begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    if (wb_regwrite !== 1'b0) begin failures++; $display("FAIL rstmid_regwrite got=%b exp=0", wb_regwrite); end
    if (result !== 32'd0)     begin failures++; $display("FAIL rstmid_result got=%h exp=0", result); end
    if (wb_wa !== 5'd0)       begin failures++; $display("FAIL rstmid_wa got=%0d exp=0", wb_wa); end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL rstmid_activity got=%0d exp=0", pulses); end
    run_op(OP_MULLO, 32'd3, 32'd4, 5'd4, lat, res, regw, wa, bz);
    checks += 3;
    if (lat !== 33)     begin failures++; $display("FAIL rstmid_fresh_latency got=%0d exp=33", lat); end
    if (res !== 32'd12) begin failures++; $display("FAIL rstmid_fresh_result got=%h exp=c", res); end
    if (regw !== 1'b1)  begin failures++; $display("FAIL rstmid_fresh_regwrite got=%b exp=1", regw); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
